regfile_wb_sched: RTL and testbench

Write-back scheduler between the SEQ write-back stage and a register file with one write port. Each retiring instruction may produce two destination writes: dstE/valE from the ALU and dstM/valM from memory. This block latches both, drives the single write port over one or two cycles, and holds off the next instruction with a valid/ready handshake. It sits after the write-back destination selection and before the register file write port.

---
 rtl/regfile_wb_sched.sv | 133 +++++++++++++
 tb/tb_regfile_wb_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: latches the E/M destination pair of a retiring instruction and
// serialises it onto a single register-file write port. Optional forwarding via `WB_FWD_EN.
module regfile_wb_sched #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int RNONE  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_done,
`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0] fwd_raddr,
`endif
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    localparam logic [ADDR_W-1:0] RN = ADDR_W'(RNONE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_E = 2'd1,
        WR_M = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] dst_e_q;
    logic [ADDR_W-1:0] dst_m_q;
    logic [DATA_W-1:0] val_e_q;
    logic [DATA_W-1:0] val_m_q;

    logic e_ok;
    logic m_ok;
    logic e_dropped;

    assign e_ok      = (dstE != RN);
    assign m_ok      = (dstM != RN);
    assign e_dropped = e_ok && m_ok && (dstE == dstM);

    assign wb_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dst_e_q  <= RN;
            dst_m_q  <= RN;
            val_e_q  <= '0;
            val_m_q  <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= RN;
            rf_wdata <= '0;
            wb_done  <= 1'b0;
        end else begin
            rf_we    <= 1'b0;
            rf_waddr <= RN;
            rf_wdata <= '0;
            wb_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_valid) begin
                        dst_e_q <= dstE;
                        dst_m_q <= dstM;
                        val_e_q <= valE;
                        val_m_q <= valM;
                        if (e_ok && !e_dropped) begin
                            state    <= WR_E;
                            rf_we    <= 1'b1;
                            rf_waddr <= dstE;
                            rf_wdata <= valE;
                            wb_done  <= !m_ok;
                        end else if (m_ok) begin
                            // Same destination on both ports: the memory value wins.
                            state    <= WR_M;
                            rf_we    <= 1'b1;
                            rf_waddr <= dstM;
                            rf_wdata <= valM;
                            wb_done  <= 1'b1;
                        end else begin
                            wb_done  <= 1'b1;
                        end
                    end
                end
                WR_E: begin
                    if (dst_m_q != RN) begin
                        state    <= WR_M;
                        rf_we    <= 1'b1;
                        rf_waddr <= dst_m_q;
                        rf_wdata <= val_m_q;
                        wb_done  <= 1'b1;
                    end else begin
                        state    <= IDLE;
                    end
                end
                WR_M: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_FWD_EN
    // M is pending in both write states; E only while its own write is in flight.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_raddr != RN && state != IDLE) begin
            if (fwd_raddr == dst_m_q) begin
                fwd_hit  = 1'b1;
                fwd_data = val_m_q;
            end else if (state == WR_E && fwd_raddr == dst_e_q) begin
                fwd_hit  = 1'b1;
                fwd_data = val_e_q;
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: queue-of-pending-writes model checked every cycle, plus literal checks.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [3:0]  dstE = 4'd15;
    logic [63:0] valE = '0;
    logic [3:0]  dstM = 4'd15;
    logic [63:0] valM = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        wb_done;
    logic [3:0]  fwd_raddr = 4'd15;
    logic        fwd_hit;
    logic [63:0] fwd_data;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb_sched dut (
        .clk(clk),
        .reset(reset),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .dstE(dstE),
        .valE(valE),
        .dstM(dstM),
        .valM(valM),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .wb_done(wb_done),
`ifdef WB_FWD_EN
        .fwd_raddr(fwd_raddr),
`endif
        .fwd_hit(fwd_hit),
        .fwd_data(fwd_data)
    );

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model: ordered list of register writes still owed; front is the one on the port now.
    typedef struct {
        logic [3:0]  a;
        logic [63:0] d;
    } wr_t;
    wr_t  sched[$];
    logic done_empty = 1'b0;
    logic mvalid = 1'b0;
    logic [63:0] shadow [16];
    int   wr_cnt [16];

    always @(posedge clk) begin
        if (reset) begin
            sched.delete();
            done_empty = 1'b0;
            mvalid = 1'b1;
        end else begin
            done_empty = 1'b0;
            if (sched.size() > 0) begin
                void'(sched.pop_front());
            end else if (wb_valid) begin
                if (dstE != 4'd15 && dstE != dstM) sched.push_back('{dstE, valE});
                if (dstM != 4'd15) sched.push_back('{dstM, valM});
                if (sched.size() == 0) done_empty = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_we, e_done, e_hit;
        logic [3:0]  e_addr;
        logic [63:0] e_data, e_fd;
        if (mvalid) begin
            e_we   = sched.size() > 0;
            e_addr = e_we ? sched[0].a : 4'd15;
            e_data = e_we ? sched[0].d : 64'd0;
            e_done = e_we ? (sched.size() == 1) : done_empty;
            e_hit  = 1'b0;
            e_fd   = '0;
            if (fwd_raddr != 4'd15) begin
                foreach (sched[i]) begin
                    if (sched[i].a == fwd_raddr) begin
                        e_hit = 1'b1;
                        e_fd  = sched[i].d;
                    end
                end
            end
`ifndef WB_FWD_EN
            e_hit = 1'b0;
            e_fd  = '0;
`endif
            cmp("wb_ready", 64'(wb_ready), 64'(!e_we));
            cmp("rf_we", 64'(rf_we), 64'(e_we));
            cmp("rf_waddr", 64'(rf_waddr), 64'(e_addr));
            cmp("rf_wdata", rf_wdata, e_data);
            cmp("wb_done", 64'(wb_done), 64'(e_done));
            cmp("fwd_hit", 64'(fwd_hit), 64'(e_hit));
            cmp("fwd_data", fwd_data, e_fd);
            if (rf_we) begin
                shadow[rf_waddr] = rf_wdata;
                wr_cnt[rf_waddr]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a request and return 2ns after the accepting edge (i.e. early in cycle N+1).
    task automatic send(input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm, output int waits);
        bit acc = 0;
        dstE = de; valE = ve; dstM = dm; valM = vm;
        wb_valid = 1'b1;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_ready) begin
                acc = 1;
                break;
            end
            waits++;
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no wb_ready, expected within 20 cycles");
        end
        tick();
        wb_valid = 1'b0;
        dstE = 4'($urandom_range(0, 15));
        dstM = 4'($urandom_range(0, 15));
        valE = {$urandom, $urandom};
        valM = {$urandom, $urandom};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0] pick [3];
        for (int i = 0; i < 16; i++) begin
            shadow[i] = '0;
            wr_cnt[i] = 0;
        end
        pick[0] = 4'd1; pick[1] = 4'd2; pick[2] = 4'd15;

        // Reset state, with inputs asserting a request that must be ignored.
        wb_valid = 1'b1; dstE = 4'd5; dstM = 4'd6;
        tick(); tick();
        cmp("rst_ready", 64'(wb_ready), 64'd1);
        cmp("rst_we", 64'(rf_we), 64'd0);
        cmp("rst_waddr", 64'(rf_waddr), 64'd15);
        cmp("rst_wdata", rf_wdata, 64'd0);
        cmp("rst_done", 64'(wb_done), 64'd0);
        cmp("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        wb_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Reset in the WR_E cycle aborts the pending M write.
        send(4'd2, 64'hAA, 4'd3, 64'hBB, w);
        cmp("abort_we_e", 64'(rf_we), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmp("abort_we", 64'(rf_we), 64'd0);
        cmp("abort_ready", 64'(wb_ready), 64'd1);
        tick(); tick();
        cmp("abort_no_r3", 64'(wr_cnt[3]), 64'd0);
        cmp("abort_r2_once", 64'(wr_cnt[2]), 64'd1);

        // Single E write; forwarding on RNONE never hits.
        fwd_raddr = 4'd15;
        send(4'd3, 64'h11, 4'd15, 64'h0, w);
        cmp("e_we", 64'(rf_we), 64'd1);
        cmp("e_addr", 64'(rf_waddr), 64'd3);
        cmp("e_data", rf_wdata, 64'h11);
        cmp("e_done", 64'(wb_done), 64'd1);
        cmp("e_ready_n1", 64'(wb_ready), 64'd0);
        cmp("e_fwd_rnone", 64'(fwd_hit), 64'd0);
        tick();
        cmp("e_ready_n2", 64'(wb_ready), 64'd1);

        // Dual write E then M.
        fwd_raddr = 4'd0;
        send(4'd4, 64'h100, 4'd0, 64'hAB, w);
        cmp("d1_addr", 64'(rf_waddr), 64'd4);
        cmp("d1_data", rf_wdata, 64'h100);
        cmp("d1_done", 64'(wb_done), 64'd0);
        cmp("d1_ready", 64'(wb_ready), 64'd0);
`ifdef WB_FWD_EN
        cmp("d1_fwd_hit", 64'(fwd_hit), 64'd1);
        cmp("d1_fwd_data", fwd_data, 64'hAB);
`endif
        tick();
        cmp("d2_addr", 64'(rf_waddr), 64'd0);
        cmp("d2_data", rf_wdata, 64'hAB);
        cmp("d2_done", 64'(wb_done), 64'd1);
        cmp("d2_ready", 64'(wb_ready), 64'd0);
        tick();
        cmp("d3_ready", 64'(wb_ready), 64'd1);
        cmp("d3_fwd_hit", 64'(fwd_hit), 64'd0);

        // Same destination: only the M value is written.
        fwd_raddr = 4'd4;
        send(4'd4, 64'h108, 4'd4, 64'h55, w);
        cmp("same_addr", 64'(rf_waddr), 64'd4);
        cmp("same_data", rf_wdata, 64'h55);
        cmp("same_done", 64'(wb_done), 64'd1);
`ifdef WB_FWD_EN
        cmp("same_fwd_data", fwd_data, 64'h55);
`endif
        tick();
        cmp("same_idle_we", 64'(rf_we), 64'd0);
        cmp("same_r4_val", shadow[4], 64'h55);
        cmp("same_r4_cnt", 64'(wr_cnt[4]), 64'd2);

        // Empty request, then an immediate back-to-back accept.
        send(4'd15, 64'h1, 4'd15, 64'h2, w);
        cmp("empty_done", 64'(wb_done), 64'd1);
        cmp("empty_we", 64'(rf_we), 64'd0);
        cmp("empty_ready", 64'(wb_ready), 64'd1);
        send(4'd5, 64'h77, 4'd15, 64'h0, w);
        cmp("b2b_waits", 64'(w), 64'd0);
        cmp("b2b_addr", 64'(rf_waddr), 64'd5);

        // Back-to-back dual write: the next request waits two extra cycles.
        send(4'd1, 64'h21, 4'd2, 64'h22, w);
        send(4'd6, 64'h66, 4'd15, 64'h0, w);
        cmp("dual_b2b_waits", 64'(w), 64'd2);

        // Mixed directed traffic, model-checked each cycle.
        for (int i = 0; i < 40; i++) begin
            fwd_raddr = pick[$urandom_range(0, 2)];
            send(pick[$urandom_range(0, 2)], 64'(i) + 64'h1000,
                 pick[$urandom_range(0, 2)], 64'(i) + 64'h2000, w);
        end
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
